// File: rtl/vscpu_pkg.sv
// Shared constants for the VSCPU MMIO responder.
// Register map offsets and control/status bit positions.
package vscpu_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  localparam logic [3:0] OFF_CYCLE     = 4'd0;
  localparam logic [3:0] OFF_TIMER_CMP = 4'd1;
  localparam logic [3:0] OFF_TIMER_CTL = 4'd2;
  localparam logic [3:0] OFF_TIMER_CNT = 4'd3;
  localparam logic [3:0] OFF_FIFO_DATA = 4'd4;
  localparam logic [3:0] OFF_FIFO_STAT = 4'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLAG   = 1;
  localparam int CTRL_RELOAD = 2;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/vscpu_sync_fifo.sv
// Synchronous FIFO with combinational head word.
// A push into a full FIFO is accepted only alongside a pop.
module vscpu_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign head   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/vscpu_mmio_responder.sv
// MMIO window: cycle counter, compare timer and output FIFO.
// Reads are registered to match block-RAM one-cycle latency.
module vscpu_mmio_responder
  import vscpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 14'h3FF0,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr_fromCPU,
  input  logic [DATA_W-1:0] data_fromCPU,
  output logic [DATA_W-1:0] data_toCPU,
  output logic              hit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  logic [DATA_W-1:0] r_cycle;
  logic [DATA_W-1:0] r_cmp;
  logic [DATA_W-1:0] r_cnt;
  logic              r_en;
  logic              r_flag;
  logic              r_reload;
  logic              r_ovf;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hit;

  logic                          w_in_win;
  logic [3:0]                    w_off;
  logic                          w_wr;
  logic                          w_wr_cmp;
  logic                          w_wr_ctl;
  logic                          w_wr_cnt;
  logic                          w_wr_stat;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(FIFO_DEPTH):0]   w_count;
  logic                          w_match;
  logic [DATA_W-1:0]             w_ctl;
  logic [DATA_W-1:0]             w_stat;
  logic [DATA_W-1:0]             w_rd;

  assign w_in_win  = (addr_fromCPU[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign w_off     = addr_fromCPU[3:0];
  assign w_wr      = wrEn && w_in_win;
  assign w_wr_cmp  = w_wr && (w_off == OFF_TIMER_CMP);
  assign w_wr_ctl  = w_wr && (w_off == OFF_TIMER_CTL);
  assign w_wr_cnt  = w_wr && (w_off == OFF_TIMER_CNT);
  assign w_wr_stat = w_wr && (w_off == OFF_FIFO_STAT);
  assign w_push    = w_wr && (w_off == OFF_FIFO_DATA);
  assign w_pop     = out_valid && out_ready;
  assign w_match   = r_en && (r_cnt == r_cmp);

  assign out_valid  = !w_empty;
  assign irq        = r_flag;
  assign data_toCPU = r_rdata;
  assign hit        = r_hit;

  vscpu_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data_fromCPU),
    .head  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_ctl              = '0;
    w_ctl[CTRL_EN]     = r_en;
    w_ctl[CTRL_FLAG]   = r_flag;
    w_ctl[CTRL_RELOAD] = r_reload;
    w_stat             = '0;
    w_stat[STAT_EMPTY] = w_empty;
    w_stat[STAT_FULL]  = w_full;
    w_stat[STAT_OVF]   = r_ovf;
    w_stat[11:8]       = 4'(w_count);
  end

  always_comb begin
    w_rd = '0;
    if (w_in_win) begin
      unique case (1'b1)
        (w_off == OFF_CYCLE):     w_rd = r_cycle;
        (w_off == OFF_TIMER_CMP): w_rd = r_cmp;
        (w_off == OFF_TIMER_CTL): w_rd = w_ctl;
        (w_off == OFF_TIMER_CNT): w_rd = r_cnt;
        (w_off == OFF_FIFO_STAT): w_rd = w_stat;
        default:                  w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle  <= '0;
      r_cmp    <= '1;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_flag   <= 1'b0;
      r_reload <= 1'b0;
      r_ovf    <= 1'b0;
      r_rdata  <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_rdata <= w_rd;
      r_hit   <= w_in_win;
      if (w_wr_cmp) r_cmp <= data_fromCPU;
      // CPU writes take priority over timer-driven updates
      if (w_wr_cnt)     r_cnt <= data_fromCPU;
      else if (w_match) r_cnt <= '0;
      else if (r_en)    r_cnt <= r_cnt + 32'd1;
      if (w_wr_ctl) begin
        r_en     <= data_fromCPU[CTRL_EN];
        r_reload <= data_fromCPU[CTRL_RELOAD];
      end else if (w_match && !r_reload) begin
        r_en <= 1'b0;
      end
      // set beats clear for both sticky flags
      if (w_match) r_flag <= 1'b1;
      else if (w_wr_ctl && data_fromCPU[CTRL_FLAG]) r_flag <= 1'b0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_stat && data_fromCPU[STAT_OVF]) r_ovf <= 1'b0;
    end
  end

endmodule
